// File: rtl/spi_exp_pkg.sv
// Shared types and constants for the SPI expander address path.
// Bit positions in the address byte are measured down from the byte MSB.
package spi_exp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_DATA      = 2'd2,
    ST_ERROR     = 2'd3
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 16;

  // Offsets from the address-byte MSB: auto-step enable, then direction.
  localparam int STEP_BIT_OFS = 1;
  localparam int DIR_BIT_OFS  = 2;

  function automatic int step_bit_pos(input int data_w);
    return data_w - STEP_BIT_OFS;
  endfunction

  function automatic int dir_bit_pos(input int data_w);
    return data_w - DIR_BIT_OFS;
  endfunction

endpackage

// File: rtl/addr_wrap_counter.sv
// Loadable register-address counter that steps up or down by one and wraps
// inside 0..NUM_REGS-1 instead of the full power-of-two range.
module addr_wrap_counter #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              dec,
  output logic [ADDR_W-1:0] count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] count_up;
  logic [ADDR_W-1:0] count_dn;

  always_comb begin
    count_up = (count == LAST) ? '0 : count + ONE;
    count_dn = (count == '0) ? LAST : count - ONE;
  end

  // Load beats step so a fresh address byte is never disturbed by a late strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      count <= dec ? count_dn : count_up;
    end
  end

endmodule

// File: rtl/spi_addr_sequencer.sv
// Address sequencer between the SPI byte deserialiser and the expander register file.
// Optional build macro ADDR_DECREMENT_EN enables a down-step direction bit in the address byte.
module spi_addr_sequencer
  import spi_exp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              reg_strobe,
  output logic              addr_err,
  output state_t            state_dbg
);

  localparam int STEP_BIT = step_bit_pos(DATA_W);
`ifdef ADDR_DECREMENT_EN
  localparam int DIR_BIT  = dir_bit_pos(DATA_W);
`endif

  // Handshake: byte_valid is a one-cycle pulse with no back-pressure. A byte is
  // consumed only in WAIT_ADDR or DATA, only when no frame event shares its cycle,
  // and (in DATA) only while reg_strobe is low; any other byte is silently dropped.

  state_t            state;
  state_t            state_nxt;
  logic              inc_en;
  logic              inc_en_nxt;
  logic              dec_en;
  logic              dec_en_nxt;
  logic              strobe_nxt;
  logic              err_nxt;
  logic              valid_nxt;
  logic              load;
  logic              addr_ok;
  logic [ADDR_W-1:0] addr_field;
  logic              unused_byte_bits;

  assign addr_field       = byte_data[ADDR_W-1:0];
  assign addr_ok          = (int'(addr_field) < NUM_REGS);
  assign unused_byte_bits = ^byte_data;
  assign state_dbg        = state;

  always_comb begin
    state_nxt  = state;
    inc_en_nxt = inc_en;
    dec_en_nxt = dec_en;
    strobe_nxt = 1'b0;
    err_nxt    = addr_err;
    load       = 1'b0;

    // Frame events dominate; any byte in the same cycle is dropped.
    if (frame_start) begin
      state_nxt = ST_WAIT_ADDR;
      err_nxt   = 1'b0;
    end else if (frame_end) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_WAIT_ADDR: begin
          if (byte_valid) begin
            if (addr_ok) begin
              load       = 1'b1;
              inc_en_nxt = byte_data[STEP_BIT];
`ifdef ADDR_DECREMENT_EN
              dec_en_nxt = byte_data[DIR_BIT];
`else
              dec_en_nxt = 1'b0;
`endif
              state_nxt  = ST_DATA;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_ERROR;
            end
          end
        end
        ST_DATA: begin
          if (byte_valid && !reg_strobe) begin
            strobe_nxt = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    valid_nxt = (state_nxt == ST_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      inc_en     <= 1'b0;
      dec_en     <= 1'b0;
      addr_valid <= 1'b0;
      reg_strobe <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      inc_en     <= inc_en_nxt;
      dec_en     <= dec_en_nxt;
      addr_valid <= valid_nxt;
      reg_strobe <= strobe_nxt;
      addr_err   <= err_nxt;
    end
  end

  // The address steps on the edge that ends the strobe, so the strobe sees the target.
  addr_wrap_counter #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (addr_field),
    .step     (reg_strobe & inc_en),
    .dec      (dec_en),
    .count    (addr_out)
  );

endmodule

// File: tb/tb_spi_addr_sequencer.sv
// Directed bench for spi_addr_sequencer: a 16-register instance and a 10-register
// instance, strobe addresses checked by a scoreboard monitor plus directed state checks.
module tb_spi_addr_sequencer;
  import spi_exp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       sel10 = 1'b0;

  logic [3:0] addr_a, addr_b;
  logic       valid_a, valid_b, strobe_a, strobe_b, err_a, err_b;
  state_t     st_a, st_b;

  logic       fs_a, fe_a, bv_a, fs_b, fe_b, bv_b;
  assign fs_a = frame_start & ~sel10;
  assign fe_a = frame_end   & ~sel10;
  assign bv_a = byte_valid  & ~sel10;
  assign fs_b = frame_start &  sel10;
  assign fe_b = frame_end   &  sel10;
  assign bv_b = byte_valid  &  sel10;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp10_q[$];
  logic [3:0] exp_a, exp_b;

  always #5 clk = ~clk;

  spi_addr_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(fs_a), .frame_end(fe_a),
    .byte_valid(bv_a), .byte_data(byte_data), .addr_out(addr_a),
    .addr_valid(valid_a), .reg_strobe(strobe_a), .addr_err(err_a), .state_dbg(st_a)
  );

  spi_addr_sequencer #(.NUM_REGS(10)) dut10 (
    .clk(clk), .rst(rst), .frame_start(fs_b), .frame_end(fe_b),
    .byte_valid(bv_b), .byte_data(byte_data), .addr_out(addr_b),
    .addr_valid(valid_b), .reg_strobe(strobe_b), .addr_err(err_b), .state_dbg(st_b)
  );

  // Scoreboard monitors: every strobe must match the next expected address.
  always @(negedge clk) begin
    if (strobe_a === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe16: unexpected strobe at addr %0d, expected none", addr_a);
      end else begin
        exp_a = exp_q.pop_front();
        if (addr_a !== exp_a || valid_a !== 1'b1) begin
          n_err++;
          $display("FAIL strobe16: addr %0d valid %0b, expected addr %0d valid 1", addr_a, valid_a, exp_a);
        end
      end
    end
    if (strobe_b === 1'b1) begin
      n_vec++;
      if (exp10_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe10: unexpected strobe at addr %0d, expected none", addr_b);
      end else begin
        exp_b = exp10_q.pop_front();
        if (addr_b !== exp_b || valid_b !== 1'b1) begin
          n_err++;
          $display("FAIL strobe10: addr %0d valid %0b, expected addr %0d valid 1", addr_b, valid_b, exp_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " addr"},   32'(addr_a),   32'd0);
    check({tag, " valid"},  32'(valid_a),  32'd0);
    check({tag, " strobe"}, 32'(strobe_a), 32'd0);
    check({tag, " err"},    32'(err_a),    32'd0);
    check({tag, " state"},  32'(st_a),     32'(ST_IDLE));
  endtask

  initial begin
    repeat (3) tick();
    check_reset_a("reset");
    rst = 1'b0;
    tick();

    // 0x83: auto-step from 3
    pulse_start();
    send_byte(8'h83);
    check("t1 addr loaded", 32'(addr_a), 32'd3);
    check("t1 state", 32'(st_a), 32'(ST_DATA));
    exp_q.push_back(4'd3); exp_q.push_back(4'd4); exp_q.push_back(4'd5);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1 valid in frame", 32'(valid_a), 32'd1);
    pulse_end();
    check("t1 addr after end", 32'(addr_a), 32'd6);
    check("t1 valid after end", 32'(valid_a), 32'd0);
    check("t1 state after end", 32'(st_a), 32'(ST_IDLE));

    // 0x0E: no auto-step, address held
    pulse_start();
    send_byte(8'h0E);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'd14);
    for (int i = 0; i < 4; i++) send_byte(8'(i));
    pulse_end();
    check("t2 addr held", 32'(addr_a), 32'd14);

    // 0x8E: wrap 15 -> 0
    pulse_start();
    send_byte(8'h8E);
    exp_q.push_back(4'd14); exp_q.push_back(4'd15); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
    for (int i = 0; i < 4; i++) send_byte(8'hA0);
    pulse_end();
    check("t3 addr after wrap", 32'(addr_a), 32'd2);

    // frame_end coincident with a data byte: byte dropped
    pulse_start();
    send_byte(8'h85);
    exp_q.push_back(4'd5);
    send_byte(8'h55);
    byte_valid = 1'b1; frame_end = 1'b1;
    tick();
    byte_valid = 1'b0; frame_end = 1'b0;
    tick();
    check("t4 state", 32'(st_a), 32'(ST_IDLE));
    check("t4 addr", 32'(addr_a), 32'd6);
    check("t4 valid", 32'(valid_a), 32'd0);

    // byte arriving during the strobe cycle is dropped
    pulse_start();
    send_byte(8'h82);
    exp_q.push_back(4'd2);
    byte_valid = 1'b1;
    tick();
    tick();
    byte_valid = 1'b0;
    tick(); tick();
    check("t5 back-to-back drop", 32'(addr_a), 32'd3);
    pulse_end();

    // frame_start restarts mid-frame and drops a simultaneous byte
    pulse_start();
    send_byte(8'h84);
    exp_q.push_back(4'd4);
    send_byte(8'h44);
    byte_data = 8'h81; byte_valid = 1'b1; frame_start = 1'b1;
    tick();
    byte_valid = 1'b0; frame_start = 1'b0;
    check("t6 restart state", 32'(st_a), 32'(ST_WAIT_ADDR));
    check("t6 restart valid", 32'(valid_a), 32'd0);
    check("t6 restart addr", 32'(addr_a), 32'd5);
    send_byte(8'h87);
    exp_q.push_back(4'd7);
    send_byte(8'h77);
    pulse_end();
    check("t6 addr after end", 32'(addr_a), 32'd8);

    // frame_start beats frame_end
    frame_start = 1'b1; frame_end = 1'b1;
    tick();
    frame_start = 1'b0; frame_end = 1'b0;
    check("t7 start wins", 32'(st_a), 32'(ST_WAIT_ADDR));
    pulse_end();

    // rst together with a pending data byte: no strobe, reset values
    pulse_start();
    send_byte(8'h89);
    byte_valid = 1'b1; rst = 1'b1;
    tick();
    byte_valid = 1'b0; rst = 1'b0;
    check_reset_a("t8 rst with byte");
    // rst during the strobe cycle: the step is suppressed too
    pulse_start();
    send_byte(8'h89);
    exp_q.push_back(4'd9);
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8 rst in strobe addr", 32'(addr_a), 32'd0);
    check("t8 rst in strobe state", 32'(st_a), 32'(ST_IDLE));

    // 0xC1: direction bit only matters with ADDR_DECREMENT_EN
    pulse_start();
    send_byte(8'hC1);
`ifdef ADDR_DECREMENT_EN
    exp_q.push_back(4'd1); exp_q.push_back(4'd0); exp_q.push_back(4'd15);
`else
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
`endif
    for (int i = 0; i < 3; i++) send_byte(8'h5A);
    pulse_end();
`ifdef ADDR_DECREMENT_EN
    check("t9 addr after dec", 32'(addr_a), 32'd14);
`else
    check("t9 addr after inc", 32'(addr_a), 32'd4);
`endif

    // NUM_REGS=10 instance: out-of-range address, then wrap at 9
    sel10 = 1'b1;
    pulse_start();
    send_byte(8'h8C);
    check("t10 err set", 32'(err_b), 32'd1);
    check("t10 state error", 32'(st_b), 32'(ST_ERROR));
    send_byte(8'h01); send_byte(8'h02);
    check("t10 err held", 32'(err_b), 32'd1);
    check("t10 valid low", 32'(valid_b), 32'd0);
    pulse_end();
    check("t10 err after end", 32'(err_b), 32'd1);
    check("t10 idle", 32'(st_b), 32'(ST_IDLE));
    pulse_start();
    check("t10 err cleared", 32'(err_b), 32'd0);
    send_byte(8'h88);
    exp10_q.push_back(4'd8); exp10_q.push_back(4'd9); exp10_q.push_back(4'd0);
    for (int i = 0; i < 3; i++) send_byte(8'h33);
    pulse_end();
    check("t10 addr after wrap", 32'(addr_b), 32'd1);
    sel10 = 1'b0;

    repeat (4) tick();
    check("queue16 drained", 32'(exp_q.size()), 32'd0);
    check("queue10 drained", 32'(exp10_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
